// File: rtl/float_accumulator.sv
// rtl/float_accumulator.sv - Packet reduction sequencer driving an external add_float
//
// Purpose:
//   Accepts a stream of floating-point elements and reduces each packet
//   (delimited by in_last) into one sum. The first element of a packet is
//   loaded directly, with its sign flipped if it is subtracted. Every later
//   element is issued to the attached add_float as one add or subtract. The
//   packet sum, element count and sticky exception flags are presented on a
//   valid/ready output.
//
// Optional feature:
//   FLOAT_ACC_SKID_EN - adds a one-entry input skid register, so the next
//   element can be taken while an add or the output handshake is in flight.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   in_valid/in_ready                 element handshake
//   in_data, in_sub, in_last          element value, subtract flag, last of packet
//   out_valid/out_ready               packet sum handshake
//   out_data, out_count               packet sum, saturating element count
//   out_nan/out_overflow/out_underflow sticky packet flags
//   add_start, add_op_sub             adder start pulse and operation
//   add_op1, add_op2                  adder operands (accumulator, element)
//   add_out, add_done                 adder result and done
//   add_nan/add_overflow/add_underflow/add_zero  adder flags (add_zero unused)

module float_accumulator #(
  parameter int FLOAT_WIDTH = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FLOAT_WIDTH-1:0] in_data,
  input  logic                   in_sub,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FLOAT_WIDTH-1:0] out_data,
  output logic                   out_nan,
  output logic                   out_overflow,
  output logic                   out_underflow,
  output logic [CNT_WIDTH-1:0]   out_count,
  output logic                   add_start,
  output logic                   add_op_sub,
  output logic [FLOAT_WIDTH-1:0] add_op1,
  output logic [FLOAT_WIDTH-1:0] add_op2,
  input  logic [FLOAT_WIDTH-1:0] add_out,
  input  logic                   add_nan,
  input  logic                   add_overflow,
  input  logic                   add_underflow,
  input  logic                   add_zero,
  input  logic                   add_done
);

  typedef enum logic [2:0] {
    ACCEPT    = 3'd0,
    ISSUE     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    OUTPUT    = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [FLOAT_WIDTH-1:0] acc_q;
  logic [FLOAT_WIDTH-1:0] elem_q;
  logic                   sub_q;
  logic                   last_q;
  logic                   first_q;
  logic                   nan_q, ovf_q, unf_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   out_valid_q;
  logic                   add_start_q;

  // Element consumed by the FSM this cycle and where it comes from.
  logic                   take;
  logic [FLOAT_WIDTH-1:0] src_data;
  logic                   src_sub;
  logic                   src_last;

  // The adder's zero flag carries no information the sum does not already hold.
  logic unused_add_zero;
  assign unused_add_zero = add_zero;

`ifdef FLOAT_ACC_SKID_EN
  logic                   skid_v_q;
  logic [FLOAT_WIDTH-1:0] skid_data_q;
  logic                   skid_sub_q;
  logic                   skid_last_q;
  logic                   skid_load;

  // A buffered element always wins over the live input; while the skid is
  // full in_ready is low, so the two can never both be taken.
  assign take      = (state_q == ACCEPT) && (skid_v_q || in_valid);
  assign src_data  = skid_v_q ? skid_data_q : in_data;
  assign src_sub   = skid_v_q ? skid_sub_q  : in_sub;
  assign src_last  = skid_v_q ? skid_last_q : in_last;
  assign skid_load = in_valid && !skid_v_q && (state_q != ACCEPT);
  assign in_ready  = !skid_v_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_sub_q  <= 1'b0;
      skid_last_q <= 1'b0;
    end else if (skid_load) begin
      skid_v_q    <= 1'b1;
      skid_data_q <= in_data;
      skid_sub_q  <= in_sub;
      skid_last_q <= in_last;
    end else if (take && skid_v_q) begin
      skid_v_q    <= 1'b0;
    end
  end
`else
  logic in_ready_q;

  assign take     = in_ready_q && in_valid;
  assign src_data = in_data;
  assign src_sub  = in_sub;
  assign src_last = in_last;
  assign in_ready = in_ready_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCEPT: begin
        if (take) begin
          if (first_q) state_d = src_last ? OUTPUT : ACCEPT;
          else         state_d = ISSUE;
        end
      end
      ISSUE:     state_d = WAIT_LOW;
      // The adder still shows the previous done right after start.
      WAIT_LOW:  if (!add_done) state_d = WAIT_HIGH;
      WAIT_HIGH: if (add_done) state_d = last_q ? OUTPUT : ACCEPT;
      OUTPUT:    if (out_ready) state_d = ACCEPT;
      default:   state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCEPT;
      acc_q       <= '0;
      elem_q      <= '0;
      sub_q       <= 1'b0;
      last_q      <= 1'b0;
      first_q     <= 1'b1;
      nan_q       <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      add_start_q <= 1'b0;
`ifndef FLOAT_ACC_SKID_EN
      in_ready_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d == OUTPUT);
      add_start_q <= (state_d == ISSUE);
`ifndef FLOAT_ACC_SKID_EN
      in_ready_q  <= (state_d == ACCEPT);
`endif

      if (take) begin
        last_q <= src_last;
        if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_q <= cnt_q + 1'b1;
        if (first_q) begin
          acc_q   <= {src_data[FLOAT_WIDTH-1] ^ src_sub, src_data[FLOAT_WIDTH-2:0]};
          first_q <= 1'b0;
        end else begin
          // Operand registers stay put until the next accepted element,
          // which cannot arrive before the capture below.
          elem_q <= src_data;
          sub_q  <= src_sub;
        end
      end

      if (state_q == WAIT_HIGH && add_done) begin
        acc_q <= add_out;
        nan_q <= nan_q | add_nan;
        ovf_q <= ovf_q | add_overflow;
        unf_q <= unf_q | add_underflow;
      end

      if (state_q == OUTPUT && out_ready) begin
        cnt_q   <= '0;
        nan_q   <= 1'b0;
        ovf_q   <= 1'b0;
        unf_q   <= 1'b0;
        first_q <= 1'b1;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = acc_q;
  assign out_count     = cnt_q;
  assign out_nan       = nan_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;
  assign add_start     = add_start_q;
  assign add_op_sub    = sub_q;
  assign add_op1       = acc_q;
  assign add_op2       = elem_q;

endmodule
